// File: rtl/hfrv_bus_tracer.sv
// hfrv_bus_tracer: passive snoop of HF-RISC-V memory bus transactions.
// One trace entry per completed access is captured into a single-entry
// stage, pushed into a show-ahead FIFO one cycle later (so read data that
// returns the cycle after accept can be merged), and drained by the
// monitor through trc_valid_o/trc_ready_i. Entries that find the FIFO full
// are dropped and reported through ovf_o and a saturating drop_cnt_o.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   - 32-bit free-running cycle counter; its value at the accept
//               edge is stored per entry and driven on trc_ts_o.
//   undefined - counter and timestamp storage are not built; trc_ts_o = 0.

module hfrv_bus_tracer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              bus_addr_i,
  input  logic [31:0]              bus_wdata_i,
  input  logic [31:0]              bus_rdata_i,
  input  logic [3:0]               bus_we_i,
  input  logic                     bus_access_i,
  input  logic                     bus_stall_i,
  output logic                     trc_valid_o,
  input  logic                     trc_ready_i,
  output logic [31:0]              trc_addr_o,
  output logic [31:0]              trc_data_o,
  output logic [3:0]               trc_we_o,
  output logic [31:0]              trc_ts_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic [15:0]              drop_cnt_o,
  input  logic                     clr_i
);

  localparam int AW = $clog2(DEPTH);

  // capture stage
  logic        accept;
  logic        stg_vld;
  logic [31:0] stg_addr;
  logic [31:0] stg_wdata;
  logic [3:0]  stg_we;

  // fifo storage and pointers (extra msb is the wrap bit)
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [3:0]  mem_we   [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        drop;
  logic [31:0] push_data;

  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  assign accept = bus_access_i & ~bus_stall_i;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] stg_ts;
  logic [31:0] mem_ts [DEPTH];

  // free-running cycle counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // capture stage: loads on every accept regardless of fifo state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_vld   <= 1'b0;
      stg_addr  <= '0;
      stg_wdata <= '0;
      stg_we    <= '0;
`ifdef TRACE_TIMESTAMP_EN
      stg_ts    <= '0;
`endif
    end else begin
      stg_vld <= accept;
      if (accept) begin
        stg_addr  <= bus_addr_i;
        stg_wdata <= bus_wdata_i;
        stg_we    <= bus_we_i;
`ifdef TRACE_TIMESTAMP_EN
        stg_ts    <= ts_cnt;
`endif
      end
    end
  end

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign pop    = ~empty & trc_ready_i;
  // a pop on the same edge frees the slot, so a full fifo still accepts
  assign wr_en  = stg_vld & (~full | pop);
  assign drop   = stg_vld & full & ~pop;

  // read data arrives the cycle after accept, i.e. at the push edge
  assign push_data = (stg_we != 4'h0) ? stg_wdata : bus_rdata_i;

  // fifo storage; cleared on reset so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
        mem_we[i]   <= '0;
`ifdef TRACE_TIMESTAMP_EN
        mem_ts[i]   <= '0;
`endif
      end
    end else if (wr_en) begin
      mem_addr[wr_idx] <= stg_addr;
      mem_data[wr_idx] <= push_data;
      mem_we[wr_idx]   <= stg_we;
`ifdef TRACE_TIMESTAMP_EN
      mem_ts[wr_idx]   <= stg_ts;
`endif
    end
  end

  // write/read pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // overflow flag and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (clr_i)                       drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clr_i) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign trc_valid_o = ~empty;
  assign trc_addr_o  = mem_addr[rd_idx];
  assign trc_data_o  = mem_data[rd_idx];
  assign trc_we_o    = mem_we[rd_idx];
  assign level_o     = wr_ptr - rd_ptr;
  assign ovf_o       = ovf_q;
  assign drop_cnt_o  = drop_cnt_q;

`ifdef TRACE_TIMESTAMP_EN
  assign trc_ts_o = mem_ts[rd_idx];
`else
  assign trc_ts_o = '0;
`endif

endmodule
